// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_if
// Purpose  : Bundle of request/status signals between the interrupt controller
//            and its environment (peripherals + single-cycle CPU control unit).
// Ports    : irq, irq_mask, s_calli, s_reti  -> into the controller
//            min_bit_s, min_bit_a, irq_pending <- out of the controller
//            master : environment side (drives requests, reads status)
//            slave  : int_ctrl side
// Revision : 1.0 - initial release
// ============================================================================
interface int_ctrl_if;
  logic [7:0] irq;
  logic [7:0] irq_mask;
  logic [7:0] s_calli;
  logic [7:0] s_reti;
  logic [7:0] min_bit_s;
  logic [7:0] min_bit_a;
  logic [7:0] irq_pending;

  modport master (
    output irq, irq_mask, s_calli, s_reti,
    input  min_bit_s, min_bit_a, irq_pending
  );

  modport slave (
    input  irq, irq_mask, s_calli, s_reti,
    output min_bit_s, min_bit_a, irq_pending
  );
endinterface : int_ctrl_if
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Purpose  : Interrupt controller for the single-cycle CPU control unit.
//            Synchronises and edge-detects raw irq lines into a pending set,
//            tracks the in-service set from the control unit's call/return
//            vectors, and presents the highest-priority (lowest index)
//            unmasked, not-in-service pending line and in-service line as
//            one-hot vectors.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-low reset
//            bus (slave) - irq, irq_mask, s_calli, s_reti in;
//                          min_bit_s, min_bit_a, irq_pending out
// Params   : SYNC_STAGES - synchroniser depth per irq line (>= 2)
//            TRAP_MASK   - lines reserved for internal traps; raw irq ignored
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TRAP_MASK   = 8'b0000_0001
) (
  input  wire logic  clk,
  input  wire logic  reset,
  int_ctrl_if.slave  bus
);

  // Synchroniser chain: r_sync[0] is the first flop, r_sync[SYNC_STAGES-1]
  // is the metastability-safe output.
  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [7:0] r_sync_d;
  logic [7:0] r_pending;
  logic [7:0] r_in_service;
  logic [7:0] r_calli_q;
  logic [7:0] r_reti_q;

  logic [7:0] w_sync_out;
  logic [7:0] w_rise;
  logic [7:0] w_take;
  logic [7:0] w_ret;
  logic [7:0] w_cand_s;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Trap lines are only ever raised internally through s_calli, so their
  // raw pins never contribute an edge.
  assign w_rise = w_sync_out & ~r_sync_d & ~TRAP_MASK;

  // The control unit holds its vectors for many cycles; only the newly set
  // bits act, so a held vector is applied exactly once.
  assign w_take = bus.s_calli & ~r_calli_q;
  assign w_ret  = bus.s_reti  & ~r_reti_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync       <= '0;
      r_sync_d     <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_calli_q    <= '0;
      r_reti_q     <= '0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], bus.irq};
      r_sync_d     <= w_sync_out;
      r_calli_q    <= bus.s_calli;
      r_reti_q     <= bus.s_reti;
      // take beats ret on the same bit; a fresh edge beats take on the same
      // bit so a request arriving while being vectored is not lost.
      r_in_service <= (r_in_service & ~w_ret) | w_take;
      r_pending    <= (r_pending & ~w_take) | w_rise;
    end
  end

  assign w_cand_s = r_pending & ~bus.irq_mask & ~r_in_service;

  // x & -x isolates the lowest set bit (bit 0 = highest priority).
  assign bus.min_bit_s   = w_cand_s & (~w_cand_s + 8'd1);
  assign bus.min_bit_a   = r_in_service & (~r_in_service + 8'd1);
  assign bus.irq_pending = r_pending;

endmodule : int_ctrl
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Purpose  : Self-checking bench for int_ctrl. A reference model tracks the
//            pending / in-service sets from sampled input history and is
//            compared with the DUT after every rising edge; directed scenarios
//            add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

  localparam int unsigned c_sync_stages = 2;
  localparam logic [7:0]  c_trap_mask   = 8'b0000_0001;

  logic clk;
  logic reset;
  int_ctrl_if bus ();

  int n_checks;
  int n_fail;

  int_ctrl #(
    .SYNC_STAGES (c_sync_stages),
    .TRAP_MASK   (c_trap_mask)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  bit         m_pend [8];
  bit         m_ins  [8];
  logic [7:0] m_hist [c_sync_stages+1];   // m_hist[0] = irq at most recent edge
  logic [7:0] m_calli_prev;
  logic [7:0] m_reti_prev;

  function automatic logic [7:0] lowest_onehot(input bit v [8]);
    for (int i = 0; i < 8; i++)
      if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] pack8(input bit v [8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit rise [8];
    bit take [8];
    bit ret  [8];
    bit cand [8];
    bit act  [8];
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 1'b0;
        m_ins[i]  = 1'b0;
      end
      for (int k = 0; k <= c_sync_stages; k++) m_hist[k] = 8'h00;
      m_calli_prev = 8'h00;
      m_reti_prev  = 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        // An edge becomes visible once the sample taken SYNC_STAGES-1 edges
        // ago is high and the one before it was low.
        rise[i] = m_hist[c_sync_stages-1][i] && !m_hist[c_sync_stages][i] && !c_trap_mask[i];
        take[i] = bus.s_calli[i] && !m_calli_prev[i];
        ret[i]  = bus.s_reti[i]  && !m_reti_prev[i];
      end
      for (int i = 0; i < 8; i++) begin
        m_ins[i]  = (m_ins[i] && !ret[i]) || take[i];
        m_pend[i] = (m_pend[i] && !take[i]) || rise[i];
      end
      for (int k = c_sync_stages; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0]    = bus.irq;
      m_calli_prev = bus.s_calli;
      m_reti_prev  = bus.s_reti;
    end
    #1;
    for (int i = 0; i < 8; i++) begin
      cand[i] = m_pend[i] && !bus.irq_mask[i] && !m_ins[i];
      act[i]  = m_ins[i];
    end
    check("model_irq_pending", bus.irq_pending, pack8(m_pend));
    check("model_min_bit_s",   bus.min_bit_s,   lowest_onehot(cand));
    check("model_min_bit_a",   bus.min_bit_a,   lowest_onehot(act));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus (inputs change on falling edges)
  // --------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_irq(input logic [7:0] v, input int n);
    bus.irq = v;
    cycles(n);
    bus.irq = 8'h00;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    bus.irq      = 8'h00;
    bus.irq_mask = 8'h00;
    bus.s_calli  = 8'h00;
    bus.s_reti   = 8'h00;
    cycles(3);
    check("reset_pending", bus.irq_pending, 8'h00);
    check("reset_min_s",   bus.min_bit_s,   8'h00);
    check("reset_min_a",   bus.min_bit_a,   8'h00);
    reset = 1'b1;
    cycles(2);

    // 1: single request, three-edge latency
    bus.irq = 8'h08;
    cycles(2);
    check("t1_not_yet", bus.irq_pending, 8'h00);
    cycles(1);
    check("t1_pending", bus.irq_pending, 8'h08);
    check("t1_min_s",   bus.min_bit_s,   8'h08);
    check("t1_min_a",   bus.min_bit_a,   8'h00);
    bus.irq = 8'h00;
    cycles(2);

    // 2: take a held vector
    pulse_irq(8'h20, 3);
    cycles(1);
    check("t2_pending", bus.irq_pending, 8'h28);
    check("t2_min_s0",  bus.min_bit_s,   8'h08);
    bus.s_calli = 8'h08;
    cycles(5);
    check("t2_min_a",   bus.min_bit_a,   8'h08);
    check("t2_min_s",   bus.min_bit_s,   8'h20);
    check("t2_pend2",   bus.irq_pending, 8'h20);

    // 3: nested higher-priority request and return
    pulse_irq(8'h02, 3);
    check("t3_min_s",   bus.min_bit_s,   8'h02);
    bus.s_calli = 8'h02;
    cycles(1);
    check("t3_min_a",   bus.min_bit_a,   8'h02);
    check("t3_min_s2",  bus.min_bit_s,   8'h20);
    bus.s_reti = 8'h02;
    cycles(1);
    check("t3_ret",     bus.min_bit_a,   8'h08);
    cycles(2);
    check("t3_ret_held", bus.min_bit_a,  8'h08);
    bus.s_reti = 8'h00;
    cycles(1);

    // 4: edge on line 4 lands on the same edge as take[4]
    bus.irq = 8'h10;
    cycles(2);
    bus.s_calli = 8'h10;
    cycles(1);
    bus.irq = 8'h00;
    check("t4_pending", bus.irq_pending, 8'h30);
    check("t4_min_a",   bus.min_bit_a,   8'h08);
    check("t4_min_s",   bus.min_bit_s,   8'h20);
    cycles(2);

    // asynchronous reset clears state without waiting for a clock edge
    reset = 1'b0;
    bus.s_calli = 8'h00;
    #1;
    check("rst1_pending", bus.irq_pending, 8'h00);
    check("rst1_min_a",   bus.min_bit_a,   8'h00);
    cycles(2);
    reset = 1'b1;
    cycles(1);

    // 5: masking is immediate, pending retained
    bus.irq_mask = 8'h10;
    pulse_irq(8'h10, 3);
    check("t5_pending", bus.irq_pending, 8'h10);
    check("t5_masked",  bus.min_bit_s,   8'h00);
    bus.irq_mask = 8'h00;
    #1;
    check("t5_unmask",  bus.min_bit_s,   8'h10);
    cycles(1);

    // repeated edge on an already pending line is absorbed
    pulse_irq(8'h10, 3);
    cycles(2);
    check("t5_absorb",  bus.irq_pending, 8'h10);

    // 6: overflow trap, irq[0] ignored, reset mid-service
    bus.s_calli = 8'h01;
    cycles(1);
    check("t6_trap_a",  bus.min_bit_a,   8'h01);
    pulse_irq(8'h01, 3);
    cycles(2);
    pulse_irq(8'h01, 3);
    cycles(3);
    check("t6_no_pend0", bus.irq_pending, 8'h10);
    reset = 1'b0;
    #1;
    check("t6_rst_a",   bus.min_bit_a,   8'h00);
    check("t6_rst_s",   bus.min_bit_s,   8'h00);
    check("t6_rst_p",   bus.irq_pending, 8'h00);
    bus.s_calli = 8'h00;
    cycles(2);
    reset = 1'b1;
    cycles(4);
    check("t6_after_a", bus.min_bit_a,   8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_int_ctrl
`default_nettype wire
